mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, cycles in BUSY without s_ready before forced completion; legal range 2..65535.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port resetn  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port m_valid  input  2  request per master; bit i = master i.
REQ-005 SHALL have port m_ready  output  2  one-cycle completion pulse per master.
REQ-006 SHALL have port m_addr  input  64  byte addresses; [31:0] master 0, [63:32] master 1.
REQ-007 SHALL have port m_wdata  input  64  write data, same packing as m_addr.
REQ-008 SHALL have port m_wstrb  input  8  byte strobes; [3:0] master 0, [7:4] master 1; all zero = read.
REQ-009 SHALL have port m_rdata  output  32  read data broadcast to both masters.
REQ-010 SHALL have ports s_valid/s_ready/s_addr/s_wdata/s_wstrb/s_rdata  out/in/out/out/out/in  1/1/32/32/4/32  native memory interface to the shared slave.
REQ-011 SHALL have port owner  output  2  one-hot current grant; 2'b00 when idle.
REQ-012 SHALL have port timeout_err  output  1  one-cycle pulse on forced completion.

Function
REQ-013 SHALL implement states IDLE, BUSY.
REQ-014 In IDLE with any m_valid bit set: grant one master, set owner, enter BUSY at the next edge; s_valid rises the cycle after m_valid is sampled (latency 1).
REQ-015 Arbitration SHALL be round-robin: on simultaneous requests, the master not served last wins; a lone requester always wins.
REQ-016 In BUSY: s_valid=1; s_addr/s_wdata/s_wstrb combinationally muxed from the granted master's fields.
REQ-017 In IDLE: s_valid=0, s_addr/s_wdata/s_wstrb=0.
REQ-018 m_ready[g] SHALL equal s_ready while BUSY with grant g; the other bit SHALL be 0; both 0 in IDLE.
REQ-019 m_rdata SHALL equal s_rdata combinationally in all states.
REQ-020 On s_ready in BUSY: update last-served pointer to g, clear owner, return to IDLE at the same edge; at least one IDLE cycle always separates consecutive grants.
REQ-021 Grant SHALL be held until completion even if the granted master drops m_valid; the non-granted master's m_valid SHALL be ignored while BUSY.
REQ-022 s_ready asserted in IDLE SHALL be ignored.

Reset
REQ-023 resetn low SHALL immediately force IDLE, owner=0, s_valid=0, m_ready=0, timeout_err=0, pointer=master 1 (so master 0 wins the first tie), timeout counter=0.
REQ-024 Reset mid-BUSY SHALL abandon the transfer with no m_ready pulse.

Configuration
REQ-025 Macro MEM_ARB_TIMEOUT_EN SHALL control the watchdog.
REQ-026 With MEM_ARB_TIMEOUT_EN defined: 16-bit counter clears on entering BUSY and increments each BUSY cycle without s_ready. When it reaches TIMEOUT_CYCLES-1 without s_ready:
- pulse m_ready[g] with m_rdata=32'hDEAD_BEEF
- pulse timeout_err
- return to IDLE as in REQ-020
s_ready in that same cycle takes precedence: normal completion, no error.
REQ-027 Without MEM_ARB_TIMEOUT_EN: no counter; BUSY waits indefinitely; timeout_err tied 0; m_rdata always equals s_rdata.

Verification
REQ-028 Single read: m_valid=01, m_addr[31:0]=0x100, wstrb=0; slave returns 0x12345678 one cycle after s_valid -> s_addr=0x100, m_ready=01 with m_rdata=0x12345678, owner=01 for 2 cycles.
REQ-029 Simultaneous requests after reset: m_valid=11, both held -> master 0 served first, then master 1, then master 0; each grant separated by one IDLE cycle.
REQ-030 Write pass-through: master 1 writes 0xCAFEF00D, wstrb=4'b0011, to 0x2000_0000 -> s_wdata=0xCAFEF00D, s_wstrb=0011, m_ready=10, m_ready[0] never set.
REQ-031 Timeout (macro on, TIMEOUT_CYCLES=8): slave never asserts s_ready -> after 8 BUSY cycles, m_ready pulse with m_rdata=0xDEADBEEF and timeout_err=1 for one cycle; s_valid then 0. Macro off -> still BUSY after 1000 cycles, timeout_err=0.
REQ-032 Reset mid-BUSY: assert resetn=0 during BUSY -> s_valid, owner, m_ready all 0 immediately, no m_ready pulse. After release with m_valid=11 -> master 0 granted.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter in front of a single native-memory slave.
// Optional BUSY watchdog is compiled in with `define MEM_ARB_TIMEOUT_EN.
module mem_arbiter #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [1:0]  m_valid,
   output logic [1:0]  m_ready,
   input  logic [63:0] m_addr,
   input  logic [63:0] m_wdata,
   input  logic [7:0]  m_wstrb,
   output logic [31:0] m_rdata,
   output logic        s_valid,
   input  logic        s_ready,
   output logic [31:0] s_addr,
   output logic [31:0] s_wdata,
   output logic [3:0]  s_wstrb,
   input  logic [31:0] s_rdata,
   output logic [1:0]  owner,
   output logic        timeout_err
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t r_state, w_state_nxt;
   logic   r_grant, w_grant_nxt;
   logic   r_last,  w_last_nxt;
   logic   w_busy, w_done, w_tout;
   logic [1:0] w_onehot;

   assign w_busy   = (r_state == BUSY);
   assign w_onehot = {r_grant, ~r_grant};
   assign w_done   = w_busy && (s_ready || w_tout);

`ifdef MEM_ARB_TIMEOUT_EN
   logic [15:0] r_cnt;

   // Force completion on the last allowed cycle unless the slave answers in it.
   assign w_tout = w_busy && !s_ready && (r_cnt == 16'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         r_cnt <= '0;
      else if (!w_busy)
         r_cnt <= '0;
      else if (!w_done)
         r_cnt <= r_cnt + 16'd1;
   end
`else
   logic w_unused_to;
   assign w_unused_to = ^16'(TIMEOUT_CYCLES);
   assign w_tout      = 1'b0;
`endif

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= IDLE;
         r_grant <= 1'b0;
         r_last  <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_grant <= w_grant_nxt;
         r_last  <= w_last_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_grant_nxt = r_grant;
      w_last_nxt  = r_last;
      case (r_state)
         IDLE: begin
            if (|m_valid) begin
               w_state_nxt = BUSY;
               // On a tie the master not served last wins.
               w_grant_nxt = (m_valid == 2'b11) ? ~r_last : m_valid[1];
            end
         end
         BUSY: begin
            if (w_done) begin
               w_state_nxt = IDLE;
               w_last_nxt  = r_grant;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      s_valid = w_busy;
      owner   = w_busy ? w_onehot : 2'b00;
      m_ready = w_done ? w_onehot : 2'b00;
      s_addr  = '0;
      s_wdata = '0;
      s_wstrb = '0;
      if (w_busy) begin
         s_addr  = r_grant ? m_addr[63:32]  : m_addr[31:0];
         s_wdata = r_grant ? m_wdata[63:32] : m_wdata[31:0];
         s_wstrb = r_grant ? m_wstrb[7:4]   : m_wstrb[3:0];
      end
      m_rdata     = w_tout ? 32'hDEAD_BEEF : s_rdata;
      timeout_err = w_tout;
   end

endmodule
